// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scanner. It has a programmable slot length, guard
// blanking at the start of each slot and a per-frame snapshot of the display data.
// It also provides leading-zero suppression, global blanking and selectable output polarity.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned DIV_WIDTH      = 16,
  parameter int unsigned GUARD_CYCLES   = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic                    blank_en,
  input  logic                    lz_suppress,
  input  logic [DIV_WIDTH-1:0]    div_limit,
  output logic [NUM_DIGITS-1:0]   select,
  output logic [7:0]              seg,
  output logic                    frame_done
);

  localparam int unsigned            PosW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PosW-1:0]        LastPos  = PosW'(NUM_DIGITS - 1);
  localparam logic [DIV_WIDTH:0]     GuardVal = (DIV_WIDTH + 1)'(GUARD_CYCLES);
  localparam logic [7:0]             SegMask  = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0]  SelMask  = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  // Hex nibble to {A..G, DP}; DP is always 0 here and merged in separately.
  function automatic logic [7:0] seg7_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    return 8'hFC;
      4'h1:    return 8'h60;
      4'h2:    return 8'hDA;
      4'h3:    return 8'hF2;
      4'h4:    return 8'h66;
      4'h5:    return 8'hB6;
      4'h6:    return 8'hBE;
      4'h7:    return 8'hE0;
      4'h8:    return 8'hFE;
      4'h9:    return 8'hF6;
      4'hA:    return 8'hEE;
      4'hB:    return 8'h3E;
      4'hC:    return 8'h9C;
      4'hD:    return 8'h7A;
      4'hE:    return 8'h9E;
      default: return 8'h8E;
    endcase
  endfunction

  logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
  logic [PosW-1:0]         pos_q, pos_d;
  logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    load_pending_q, load_pending_d;
  logic [NUM_DIGITS-1:0]   select_q, select_d;
  logic [7:0]              seg_q, seg_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick, wrap;
  logic [NUM_DIGITS-1:0]   lz_zero;
  logic [3:0]              cur_nib;
  logic [7:0]              seg_ag;
  logic                    suppress, lit;
  logic [NUM_DIGITS-1:0]   sel_raw;
  logic [7:0]              seg_raw;

  // Prescaler, scan position and frame-coherent snapshot.
  always_comb begin
    // >= so that shrinking div_limit mid-slot ends the slot on the next clock.
    tick            = (cnt_q >= div_limit);
    wrap            = tick && (pos_q == LastPos);
    cnt_d           = tick ? '0 : cnt_q + 1'b1;
    pos_d           = pos_q;
    if (tick) pos_d = wrap ? '0 : pos_q + 1'b1;
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    if (wrap || load_pending_q) begin
      shadow_digits_d = digits;
      shadow_dp_d     = dp_en;
    end
    load_pending_d  = 1'b0;
    frame_done_d    = wrap;
  end

  // Segment/select generation for the current slot, polarity applied last.
  always_comb begin
    lz_zero = '0;
    begin : lz_scan
      logic acc;
      acc = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
        acc        = acc && (shadow_digits_q[4*i +: 4] == 4'h0);
        lz_zero[i] = acc;
      end
    end
    cur_nib  = shadow_digits_q[{pos_q, 2'b00} +: 4];
    seg_ag   = seg7_decode(cur_nib);
    suppress = lz_suppress && (pos_q != '0) && lz_zero[pos_q];
    lit      = ({1'b0, cnt_q} >= GuardVal) && !blank_en;
    seg_raw  = {(suppress ? 7'b0 : seg_ag[7:1]), shadow_dp_q[pos_q]};
    sel_raw  = '0;
    sel_raw[pos_q] = 1'b1;
    if (!lit) begin
      sel_raw = '0;
      seg_raw = '0;
    end
    select_d = sel_raw ^ SelMask;
    seg_d    = seg_raw ^ SegMask;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      pos_q           <= '0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      load_pending_q  <= 1'b1;
      select_q        <= SelMask;
      seg_q           <= SegMask;
      frame_done_q    <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      pos_q           <= pos_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      load_pending_q  <= load_pending_d;
      select_q        <= select_d;
      seg_q           <= seg_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign select     = select_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: two 4-digit scanners (normal and inverted polarity) on shared inputs.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic        blank_en;
  logic        lz_suppress;
  logic [7:0]  div_limit;
  logic [3:0]  sel_a, sel_b;
  logic [7:0]  seg_a, seg_b;
  logic        fd_a, fd_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .DIV_WIDTH(8), .GUARD_CYCLES(1), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_en(dp_en), .blank_en(blank_en),
    .lz_suppress(lz_suppress), .div_limit(div_limit), .select(sel_a), .seg(seg_a),
    .frame_done(fd_a)
  );

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .DIV_WIDTH(8), .GUARD_CYCLES(1), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_en(dp_en), .blank_en(blank_en),
    .lz_suppress(lz_suppress), .div_limit(div_limit), .select(sel_b), .seg(seg_b),
    .frame_done(fd_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // es/eseg are active-high expectations; the inverted DUT must show their complement.
  task automatic check_all(input string tag, input logic [3:0] es, input logic [7:0] eseg,
                           input logic efd);
    chk({tag, " sel_a"}, {4'h0, sel_a}, {4'h0, es});
    chk({tag, " seg_a"}, seg_a, eseg);
    chk({tag, " fd_a"}, {7'h0, fd_a}, {7'h0, efd});
    chk({tag, " sel_b"}, {4'h0, sel_b}, {4'h0, ~es});
    chk({tag, " seg_b"}, seg_b, ~eseg);
    chk({tag, " fd_b"}, {7'h0, fd_b}, {7'h0, efd});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    check_all("reset", 4'h0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  // One 16-clock frame starting at cnt=0,pos=0; exp_segs byte s is slot s's lit pattern.
  task automatic run_frame(input string tag, input logic [31:0] exp_segs, input logic dark,
                           input int chg_step, input logic [15:0] chg_digits);
    for (int k = 0; k < 16; k++) begin
      int s;
      int c;
      logic [3:0] es;
      logic [7:0] eseg;
      s    = k / 4;
      c    = k % 4;
      step();
      es   = (c == 0 || dark) ? 4'h0 : (4'h1 << s);
      eseg = (c == 0 || dark) ? 8'h00 : exp_segs[8*s +: 8];
      check_all($sformatf("%s k%0d", tag, k), es, eseg, (k == 15));
      if (k == chg_step) digits = chg_digits;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    digits      = 16'h1234;
    dp_en       = 4'b0000;
    blank_en    = 1'b0;
    lz_suppress = 1'b0;
    div_limit   = 8'd3;

    // Basic scan: digit0=4, digit1=3, digit2=2, digit3=1.
    do_reset();
    run_frame("scan1", 32'h60_DA_F2_66, 1'b0, -1, 16'h0);
    run_frame("scan2", 32'h60_DA_F2_66, 1'b0, -1, 16'h0);

    // Leading-zero suppression with DP on a suppressed digit.
    digits      = 16'h0050;
    lz_suppress = 1'b1;
    dp_en       = 4'b1000;
    do_reset();
    run_frame("lz", 32'h01_00_B6_FC, 1'b0, -1, 16'h0);

    // Snapshot: change during slot 2 is invisible until the next frame.
    digits      = 16'h1111;
    lz_suppress = 1'b0;
    dp_en       = 4'b0000;
    do_reset();
    run_frame("snap_old", 32'h60_60_60_60, 1'b0, 8, 16'h2222);
    run_frame("snap_new", 32'hDA_DA_DA_DA, 1'b0, -1, 16'h0);

    // Global blanking for one frame, then resume.
    blank_en = 1'b1;
    run_frame("blank", 32'h0, 1'b1, -1, 16'h0);
    blank_en = 1'b0;
    run_frame("unblank", 32'hDA_DA_DA_DA, 1'b0, -1, 16'h0);

    // Digit 8 on both polarities (inverted DUT shows seg=01).
    digits = 16'h8888;
    do_reset();
    run_frame("eight", 32'hFE_FE_FE_FE, 1'b0, -1, 16'h0);

    // Reset in the middle of slot 2 restarts at digit 0 with a fresh snapshot.
    digits = 16'h1234;
    do_reset();
    for (int k = 0; k < 10; k++) step();
    digits = 16'h0005;
    do_reset();
    run_frame("rstmid", 32'hFC_FC_FC_B6, 1'b0, -1, 16'h0);

    // div_limit 7 -> 1 while cnt=5 ends the slot on the next clock.
    digits    = 16'h1234;
    div_limit = 8'd7;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    check_all("div e5", 4'b0001, 8'h66, 1'b0);
    div_limit = 8'd1;
    step();
    check_all("div e6", 4'b0001, 8'h66, 1'b0);
    step();
    check_all("div e7", 4'b0000, 8'h00, 1'b0);
    step();
    check_all("div e8", 4'b0010, 8'hF2, 1'b0);
    step();
    check_all("div e9", 4'b0000, 8'h00, 1'b0);
    step();
    check_all("div e10", 4'b0100, 8'hDA, 1'b0);

    // div_limit=0: 1-clock slots, guard keeps it dark, frame every 4 clocks.
    div_limit = 8'd0;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      check_all($sformatf("div0 e%0d", k), 4'h0, 8'h00, (k % 4 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
